expand_u_to_s_stream: RTL

//  Streaming inverse of the signed->unsigned positive clamp: converts unsigned INW-bit samples
//  (e.g. 8-bit pixel/colour values) back into signed OUTW-bit working values.

---
 rtl/expand_pkg.sv | 22 ++
 rtl/expand_u_to_s_stream_sat_clamp.sv | 35 +++
 rtl/expand_u_to_s_stream.sv | 138 +++++++++++++
 3 files changed

// File: rtl/expand_pkg.sv
// Shared types and helpers for the unsigned->signed expand stream.
// Signed range helpers and the stage-1 payload carried between pipeline stages.
package expand_pkg;

    localparam int unsigned D1_MAXW = 32;
    localparam int unsigned SH_MAXW = 8;

    // Container widths are fixed here; the top sign/zero-extends into them.
    typedef struct packed {
        logic signed [D1_MAXW-1:0] d1;
        logic        [SH_MAXW-1:0] shift;
    } s1_payload_t;

    function automatic longint SMAX(input int unsigned w);
        return (longint'(1) << (w - 1)) - 64'sd1;
    endfunction

    function automatic longint SMIN(input int unsigned w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/expand_u_to_s_stream_sat_clamp.sv
// Combinational signed clamp from IW bits down to OW bits, flagging saturation.
module sat_clamp_s
    import expand_pkg::*;
#(
    parameter int unsigned IW = 24,
    parameter int unsigned OW = 16
) (
    input  logic signed [IW-1:0] din_i,
    output logic signed [OW-1:0] dout_o,
    output logic                 sat_o
);

    if (IW > OW) begin : g_clamp
        localparam logic signed [IW-1:0] MAXW = IW'(SMAX(OW));
        localparam logic signed [IW-1:0] MINW = IW'(SMIN(OW));
        localparam logic signed [OW-1:0] MAXO = OW'(SMAX(OW));
        localparam logic signed [OW-1:0] MINO = OW'(SMIN(OW));

        always_comb begin
            dout_o = din_i[OW-1:0];
            sat_o  = 1'b0;
            if (din_i > MAXW) begin
                dout_o = MAXO;
                sat_o  = 1'b1;
            end else if (din_i < MINW) begin
                dout_o = MINO;
                sat_o  = 1'b1;
            end
        end
    end else begin : g_pass
        assign dout_o = OW'(din_i);
        assign sat_o  = 1'b0;
    end

endmodule

// File: rtl/expand_u_to_s_stream.sv
// Two-stage valid/ready pipe computing sat((in - bias) <<< shift) into signed OUTW bits.
// Optional saturation counter enabled by defining EXPAND_STATS_EN.
module expand_u_to_s_stream
    import expand_pkg::*;
#(
    parameter int unsigned INW  = 8,
    parameter int unsigned OUTW = 16,
    parameter int unsigned SHW  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INW-1:0]         i_data,
    input  logic [INW-1:0]         i_bias,
    input  logic [SHW-1:0]         i_shift,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [OUTW-1:0] o_data,
    output logic                   o_sat,
    output logic                   o_busy,
    input  logic                   i_statClr,
    output logic [15:0]            o_satCount
);

    localparam int unsigned WW = INW + 2**SHW;

    if (OUTW < INW + 2) begin : g_bad_outw
        $error("expand_u_to_s_stream: OUTW must be >= INW+2");
    end
    if ((INW + 1 > D1_MAXW) || (SHW > SH_MAXW)) begin : g_bad_payload
        $error("expand_u_to_s_stream: INW/SHW exceed payload container");
    end

    logic                   s1_valid_q, s1_valid_d;
    s1_payload_t            s1_q, s1_d;
    logic                   s2_valid_q, s2_valid_d;
    logic signed [OUTW-1:0] s2_data_q, s2_data_d;
    logic                   s2_sat_q, s2_sat_d;

    logic                   s1_load, s2_load, in_xfer;
    logic signed [INW:0]    diff;
    logic signed [WW-1:0]   wide;
    logic signed [OUTW-1:0] clamped;
    logic                   clamp_sat;

    sat_clamp_s #(
        .IW (WW),
        .OW (OUTW)
    ) u_clamp (
        .din_i  (wide),
        .dout_o (clamped),
        .sat_o  (clamp_sat)
    );

    always_comb begin
        s2_load = !s2_valid_q || i_ready;
        s1_load = !s1_valid_q || s2_load;
        in_xfer = i_valid && s1_load;

        diff = $signed({1'b0, i_data}) - $signed({1'b0, i_bias});
        wide = WW'($signed(s1_q.d1)) <<< s1_q.shift;

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_load) begin
            s1_valid_d = i_valid;
        end
        if (in_xfer) begin
            s1_d.d1    = D1_MAXW'(diff);
            s1_d.shift = SH_MAXW'(i_shift);
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            // Result registers only move on a real beat so o_data stays put when idle.
            if (s1_valid_q) begin
                s2_data_d = clamped;
                s2_sat_d  = clamp_sat;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    assign o_ready = s1_load;
    assign o_valid = s2_valid_q;
    assign o_data  = s2_data_q;
    assign o_sat   = s2_sat_q;
    assign o_busy  = s1_valid_q || s2_valid_q;

`ifdef EXPAND_STATS_EN
    logic        out_xfer;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        out_xfer  = s2_valid_q && i_ready;
        sat_cnt_d = sat_cnt_q;
        if (i_statClr) begin
            sat_cnt_d = '0;
        end else if (out_xfer && s2_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_satCount = sat_cnt_q;
`else
    logic unused_statclr;
    assign unused_statclr = i_statClr;
    assign o_satCount     = '0;
`endif

endmodule
